// File: rtl/llabs_pkg.sv
// Shared constants and types for the video-memory pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package llabs_pkg;
  localparam int GRID_COLS   = 34;
  localparam int GRID_ROWS   = 33;
  localparam int VMEM_DEPTH  = 1122;
  localparam int VMEM_ADDR_W = 11;
  localparam int COLOR_W     = 3;
  localparam int RECT_CRD_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_DONE  = 2'd2
  } painter_state_e;
endpackage

// File: rtl/rect_painter_if.sv
// Start/done continuation handshake plus the RAM write port of the painter.
// Latency: n/a (wiring only).
// Backpressure: done is held by the painter until the master acks it.
interface rect_painter_if;
  import llabs_pkg::*;

  logic                    in_cont_signal;
  logic [RECT_CRD_W-1:0]   rect_x;
  logic [RECT_CRD_W-1:0]   rect_y;
  logic [RECT_CRD_W-1:0]   rect_w;
  logic [RECT_CRD_W-1:0]   rect_h;
  logic [COLOR_W-1:0]      rect_color;
  logic                    next_out_cont_signal;
  logic                    out_cont_signal;
  logic                    busy;
  logic [VMEM_ADDR_W-1:0]  address;
  logic [COLOR_W-1:0]      color;
  logic                    print_enable;

  modport master (
    output in_cont_signal, rect_x, rect_y, rect_w, rect_h, rect_color,
           next_out_cont_signal,
    input  out_cont_signal, busy, address, color, print_enable
  );

  modport slave (
    input  in_cont_signal, rect_x, rect_y, rect_w, rect_h, rect_color,
           next_out_cont_signal,
    output out_cont_signal, busy, address, color, print_enable
  );
endinterface

// File: rtl/grid_addr_calc.sv
// Maps a (cx,cy) cell to its linear video-memory address cy*COLS+cx.
// Latency: combinational, no registers.
// Backpressure: none.
module grid_addr_calc
  import llabs_pkg::*;
#(
  parameter int COLS   = GRID_COLS,
  parameter int CRD_W  = RECT_CRD_W,
  parameter int ADDR_W = VMEM_ADDR_W
) (
  input  logic [CRD_W-1:0]  i_cx,
  input  logic [CRD_W-1:0]  i_cy,
  output logic [ADDR_W-1:0] o_addr
);
  localparam logic [ADDR_W-1:0] L_COLS = ADDR_W'(COLS);

  logic [ADDR_W-1:0] w_cy_ext;
  logic [ADDR_W-1:0] w_sum;

  // Multiply by the constant stride as a sum of shifted copies of cy.
  always_comb begin
    w_cy_ext = ADDR_W'(i_cy);
    w_sum    = ADDR_W'(i_cx);
    for (int i = 0; i < ADDR_W; i++) begin
      if (L_COLS[i]) w_sum = w_sum + (w_cy_ext << i);
    end
  end

  assign o_addr = w_sum;
endmodule

// File: rtl/rect_painter.sv
// Fills a clipped rectangle of the cell grid with one colour, one RAM write per clock.
// Latency: first write 1 cycle after start, W*H back-to-back writes, done the cycle after.
// Backpressure: none on writes; done held until next_out_cont_signal acks it.
module rect_painter
  import llabs_pkg::*;
#(
  parameter int COLS   = GRID_COLS,
  parameter int ROWS   = GRID_ROWS,
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int CRD_W  = RECT_CRD_W
) (
  input logic           Clck,
  input logic           Reset,
  rect_painter_if.slave bus
);
  localparam logic [CRD_W:0] L_COLS = (CRD_W+1)'(COLS);
  localparam logic [CRD_W:0] L_ROWS = (CRD_W+1)'(ROWS);
  localparam logic [CRD_W:0] L_ONE  = (CRD_W+1)'(1);

  painter_state_e     r_state, w_state;
  logic [CRD_W-1:0]   r_x, w_x, r_cx, w_cx, r_cy, w_cy;
  logic [CRD_W:0]     r_xe, w_xe, r_ye, w_ye;
  logic [COLOR_W-1:0] r_color, w_color;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic               r_pe, w_pe, r_done, w_done, r_busy, w_busy;

  logic [CRD_W:0]     w_x_sum, w_y_sum, w_xe_clip, w_ye_clip, w_cx_inc, w_cy_inc;
  logic [CRD_W-1:0]   w_ncx, w_ncy;
  logic [ADDR_W-1:0]  w_calc_addr;
  logic               w_empty, w_row_end, w_last;

  // Sums carry one extra bit so a large x+w cannot wrap below the grid edge.
  assign w_x_sum   = {1'b0, bus.rect_x} + {1'b0, bus.rect_w};
  assign w_y_sum   = {1'b0, bus.rect_y} + {1'b0, bus.rect_h};
  assign w_xe_clip = (w_x_sum > L_COLS) ? L_COLS : w_x_sum;
  assign w_ye_clip = (w_y_sum > L_ROWS) ? L_ROWS : w_y_sum;
  assign w_empty   = (bus.rect_w == '0) || (bus.rect_h == '0) ||
                     ({1'b0, bus.rect_x} >= L_COLS) || ({1'b0, bus.rect_y} >= L_ROWS);

  assign w_cx_inc  = {1'b0, r_cx} + L_ONE;
  assign w_cy_inc  = {1'b0, r_cy} + L_ONE;
  assign w_row_end = (w_cx_inc == r_xe);
  assign w_last    = w_row_end && (w_cy_inc == r_ye);

  // Cell to be presented next: the top-left corner on start, else raster successor.
  always_comb begin
    w_ncx = r_cx;
    w_ncy = r_cy;
    if (r_state == ST_IDLE) begin
      w_ncx = bus.rect_x;
      w_ncy = bus.rect_y;
    end else if (w_row_end) begin
      w_ncx = r_x;
      w_ncy = r_cy + CRD_W'(1);
    end else begin
      w_ncx = r_cx + CRD_W'(1);
    end
  end

  grid_addr_calc #(
    .COLS   (COLS),
    .CRD_W  (CRD_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .i_cx   (w_ncx),
    .i_cy   (w_ncy),
    .o_addr (w_calc_addr)
  );

  // Next-state and next-output logic; write strobe defaults low every cycle.
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_xe    = r_xe;
    w_ye    = r_ye;
    w_cx    = r_cx;
    w_cy    = r_cy;
    w_color = r_color;
    w_addr  = r_addr;
    w_pe    = 1'b0;
    w_done  = r_done;
    w_busy  = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.in_cont_signal) begin
          w_x     = bus.rect_x;
          w_xe    = w_xe_clip;
          w_ye    = w_ye_clip;
          w_color = bus.rect_color;
          w_busy  = 1'b1;
          if (w_empty) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = ST_PAINT;
            w_cx    = w_ncx;
            w_cy    = w_ncy;
            w_addr  = w_calc_addr;
            w_pe    = 1'b1;
          end
        end
      end
      ST_PAINT: begin
        if (w_last) begin
          w_state = ST_DONE;
          w_done  = 1'b1;
        end else begin
          w_cx   = w_ncx;
          w_cy   = w_ncy;
          w_addr = w_calc_addr;
          w_pe   = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.next_out_cont_signal) begin
          w_state = ST_IDLE;
          w_done  = 1'b0;
          w_busy  = 1'b0;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any fill in progress.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_color <= '0;
      r_addr  <= '0;
      r_pe    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_xe    <= w_xe;
      r_ye    <= w_ye;
      r_cx    <= w_cx;
      r_cy    <= w_cy;
      r_color <= w_color;
      r_addr  <= w_addr;
      r_pe    <= w_pe;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign bus.out_cont_signal = r_done;
  assign bus.busy            = r_busy;
  assign bus.address         = r_addr;
  assign bus.color           = r_color;
  assign bus.print_enable    = r_pe;
endmodule

// File: tb/tb_rect_painter.sv
// Self-checking bench for rect_painter against a raster-order list model.
// Latency: checks first write at start+1, done at start+W*H+1.
// Backpressure: random ack delays while done is held.
module tb_rect_painter;
  import llabs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rect_painter_if bus();

  rect_painter dut (
    .Clck  (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [COLOR_W-1:0] ram [VMEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"},  bus.out_cont_signal, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_pe"},    bus.print_enable, 0);
    chk({tag, "_addr"},  bus.address, 0);
    chk({tag, "_color"}, bus.color, 0);
  endtask

  // Starts a fill and checks every cycle until it is acked (or reset at write abort_at).
  task automatic run_fill(input int x, input int y, input int w, input int h, input int c,
                          input int ack_wait, input bit poke, input int abort_at);
    int exp_addr[$];
    int n;
    int late_done;
    for (int yy = y; yy < y + h && yy < GRID_ROWS; yy++)
      for (int xx = x; xx < x + w && xx < GRID_COLS; xx++)
        exp_addr.push_back(yy * GRID_COLS + xx);
    n = exp_addr.size();

    bus.rect_x         = RECT_CRD_W'(x);
    bus.rect_y         = RECT_CRD_W'(y);
    bus.rect_w         = RECT_CRD_W'(w);
    bus.rect_h         = RECT_CRD_W'(h);
    bus.rect_color     = COLOR_W'(c);
    bus.in_cont_signal = 1'b1;
    tick();
    bus.in_cont_signal = 1'b0;
    // Inputs are latched at start, so scrambling them now must not matter.
    bus.rect_x     = RECT_CRD_W'($urandom);
    bus.rect_y     = RECT_CRD_W'($urandom);
    bus.rect_w     = RECT_CRD_W'($urandom);
    bus.rect_h     = RECT_CRD_W'($urandom);
    bus.rect_color = COLOR_W'($urandom);

    for (int k = 1; k <= n; k++) begin
      chk("wr_pe", bus.print_enable, 1);
      chk("wr_addr", bus.address, exp_addr[k-1]);
      chk("wr_color", bus.color, c);
      chk("wr_done_low", bus.out_cont_signal, 0);
      chk("wr_busy", bus.busy, 1);
      if (bus.print_enable === 1'b1 && bus.address < VMEM_DEPTH) ram[bus.address] = bus.color;
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("abort");
        late_done = 0;
        for (int i = 0; i < 12; i++) begin
          tick();
          if (bus.out_cont_signal !== 1'b0 || bus.print_enable !== 1'b0) late_done++;
        end
        chk("abort_quiet", late_done, 0);
        return;
      end
      if (poke && k == (n + 1) / 2) bus.in_cont_signal = 1'b1;
      tick();
      bus.in_cont_signal = 1'b0;
    end

    chk("done_rise", bus.out_cont_signal, 1);
    chk("done_pe", bus.print_enable, 0);
    chk("done_busy", bus.busy, 1);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("done_hold", bus.out_cont_signal, 1);
      chk("done_hold_pe", bus.print_enable, 0);
    end

    bus.next_out_cont_signal = 1'b1;
    if (poke) bus.in_cont_signal = 1'b1;
    tick();
    bus.next_out_cont_signal = 1'b0;
    bus.in_cont_signal       = 1'b0;
    chk("ack_done_clr", bus.out_cont_signal, 0);
    chk("ack_busy_clr", bus.busy, 0);
    chk("ack_pe", bus.print_enable, 0);
    tick();
    chk("idle_pe", bus.print_enable, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int stray;
    int bad;
    int rx, ry, rw, rh;

    bus.in_cont_signal       = 1'b0;
    bus.next_out_cont_signal = 1'b0;
    bus.rect_x               = '0;
    bus.rect_y               = '0;
    bus.rect_w               = '0;
    bus.rect_h               = '0;
    bus.rect_color           = '0;
    for (int i = 0; i < VMEM_DEPTH; i++) ram[i] = '0;

    // Reset held three cycles, then a quiet idle period.
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.print_enable !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    chk("reset_quiet", stray, 0);

    // Small interior rectangle, ack held off a few cycles.
    run_fill(2, 3, 3, 2, 5, 3, 1'b0, 0);
    // Corner clipping, zero width, and an origin off the grid.
    run_fill(32, 32, 5, 5, 6, 1, 1'b0, 0);
    run_fill(4, 4, 0, 3, 2, 0, 1'b0, 0);
    run_fill(40, 5, 3, 3, 1, 2, 1'b0, 0);
    run_fill(1, 33, 3, 3, 1, 0, 1'b0, 0);
    // Full screen.
    for (int i = 0; i < VMEM_DEPTH; i++) ram[i] = '0;
    run_fill(0, 0, 34, 33, 7, 0, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < VMEM_DEPTH; i++) if (ram[i] !== 3'd7) bad++;
    chk("ram_full_7", bad, 0);
    // Start pulses mid-fill and alongside the ack are ignored.
    run_fill(10, 10, 4, 3, 3, 2, 1'b1, 0);
    // Reset on the 4th write of a 3x3 fill.
    run_fill(5, 6, 3, 3, 4, 0, 1'b0, 4);

    // Randomized rectangles, including off-grid and clipped ones.
    for (int t = 0; t < 30; t++) begin
      rx = $urandom_range(0, 37);
      ry = $urandom_range(0, 36);
      rw = (t % 6 == 5) ? $urandom_range(0, 63) : $urandom_range(0, 8);
      rh = (t % 6 == 5) ? $urandom_range(0, 63) : $urandom_range(0, 8);
      run_fill(rx, ry, rw, rh, $urandom_range(0, 7), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
